mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Schedules the single shared instruction/data memory port between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage RISC-V pipeline. It serves each pipeline slot's fetch and data access exactly once per pipeline advance, with MEM having priority. It holds returned read data in registers and drives a global pipeline stall until both of the slot's accesses are served. It sits between the pipeline registers and the memory model, alongside the Control/hazard logic.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max cycles waiting for mem_ack_i (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
if_req_i  in  1  IF stage wants a fetch (level)
if_addr_i  in  ADDR_W  fetch address (PC)
mem_req_i  in  1  MEM stage wants an access (MemRead|MemWrite, level)
mem_we_i  in  1  1 = store, 0 = load
mem_addr_i  in  ADDR_W  data address
mem_wdata_i  in  DATA_W  store data
if_rdata_o  out  DATA_W  registered fetched instruction
mem_rdata_o  out  DATA_W  registered load data
pipe_stall_o  out  1  freeze all pipeline registers
port_req_o  out  1  memory access request (registered)
port_we_o  out  1  registered write enable
port_addr_o  out  ADDR_W  registered address
port_wdata_o  out  DATA_W  registered write data
port_ack_i  in  1  memory completes access this cycle; port_rdata_i valid
port_rdata_i  in  DATA_W  read data
err_o  out  1  sticky timeout flag (0 without MEM_ARB_TIMEOUT_EN)

Behaviour:
- Reset (rst_i low, async): state IDLE; if_served=mem_served=0; all outputs 0 except pipe_stall_o, which follows its combinational equation. Reset mid-access drops port_req_o immediately and abandons the access.
- State IDLE, port_req_o=0:
  - mem_req_i & ~mem_served -> latch mem_addr/wdata/we into port_* and go to MEM_ACC.
  - else if_req_i & ~if_served -> latch if_addr_i with we=0 and go to IF_ACC.
  - else stay in IDLE.
- MEM_ACC / IF_ACC: port_req_o=1; port_* stable.
  - port_ack_i=1 -> next state IDLE.
  - Set the matching served flag.
  - Capture port_rdata_i into if_rdata_o (IF_ACC) or mem_rdata_o (MEM_ACC, loads only; stores leave mem_rdata_o unchanged).
- port_ack_i is ignored in IDLE.
- pipe_stall_o = (if_req_i & ~if_served) | (mem_req_i & ~mem_served), combinational.
- On any clock edge where pipe_stall_o=0: clear both served flags (slot advances).
- Served-set and clear never coincide: while in ACC the requester is unserved, so stall=1.
- A served requester is never re-granted while the pipeline is held by the other requester. This is the no-duplicate-store guarantee.
- Latency: grant cycle (IDLE) -> access cycle(s) -> served cycle. Minimum 3 cycles for a slot with one access (ack in first ACC cycle). Minimum 5 cycles for a slot with both accesses (MEM first).
- rdata registers hold until the next capture.
- No request in the slot: stall=0, no port activity.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined: an 8-bit+ counter runs in ACC states and resets on entry. If it reaches TIMEOUT without ack:
  - state -> IDLE, port_req_o drops;
  - the matching served flag is set (pipeline does not hang);
  - the captured rdata is forced to 0;
  - err_o is set sticky until reset.
- Undefined: wait indefinitely for ack; err_o tied 0; no counter logic.

Test Plan:
- Reset mid-access: rst_i low during IF_ACC -> port_req_o=0 the same cycle. After release, state is IDLE and served flags are 0.
- IF-only fetch: if_req_i=1, addr 0x00000010, ack in first ACC cycle with 0x00A00093 -> port_req_o high for 1 cycle, stall high for 2 cycles. if_rdata_o=0x00A00093 in the 3rd cycle with stall=0.
- Simultaneous: if_req_i=1 at 0x14 and mem_req_i=1 load at 0x100, both acked immediately with 0x12345678 (mem) and 0x0000006F (IF) -> MEM granted first, then IF. Stall drops on cycle 5 with mem_rdata_o=0x12345678 and if_rdata_o=0x0000006F.
- Store not duplicated: store 0xDEADBEEF to 0x200 acked, while IF ack is delayed 4 cycles -> exactly one port_req_o/port_we_o=1 burst for the store. The pipeline stays stalled until the IF ack.
- Wait states: ack delayed 3 cycles -> port_addr_o/port_wdata_o/port_we_o stable for all 4 ACC cycles. Stall is held throughout.
- (MEM_ARB_TIMEOUT_EN, TIMEOUT=4) no ack -> port_req_o drops after 4 cycles, err_o=1, if_rdata_o=0, stall releases; err_o stays 1 until reset.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Shared memory-port bus between the IF/MEM port arbiter (master) and the memory model (slave).
// Request fields are registered by the master; ack/rdata come back from the memory in the same cycle.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              port_req_o;
    logic              port_we_o;
    logic [ADDR_W-1:0] port_addr_o;
    logic [DATA_W-1:0] port_wdata_o;
    logic              port_ack_i;
    logic [DATA_W-1:0] port_rdata_i;

    modport master (
        output port_req_o, port_we_o, port_addr_o, port_wdata_o,
        input  port_ack_i, port_rdata_i
    );

    modport slave (
        input  port_req_o, port_we_o, port_addr_o, port_wdata_o,
        output port_ack_i, port_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between IF fetch and MEM load/store, MEM first, once per pipeline slot.
// Optional ack timeout with sticky err_o is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              pipe_stall_o,
    output logic              err_o,
    mem_port_arbiter_if.master memPort
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_ACC = 2'd1,
        IF_ACC  = 2'd2
    } arbState_e;

    arbState_e state, stateNext;
    logic      ifServed, memServed;
    logic      grantMem, grantIf, accDone, timedOut;

    // A slot advances on any edge where nothing is left unserved.
    assign pipe_stall_o = (if_req_i & ~ifServed) | (mem_req_i & ~memServed);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] waitCnt;

    assign timedOut = (state != IDLE) && !memPort.port_ack_i &&
                      (waitCnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            waitCnt <= '0;
            err_o   <= 1'b0;
        end else begin
            if (grantMem || grantIf) begin
                waitCnt <= '0;
            end else if (state != IDLE) begin
                waitCnt <= waitCnt + 1'b1;
            end
            if (timedOut) begin
                err_o <= 1'b1;
            end
        end
    end
`else
    assign timedOut = 1'b0;
    assign err_o    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext = state;
        grantMem  = 1'b0;
        grantIf   = 1'b0;
        accDone   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_i && !memServed) begin
                    grantMem  = 1'b1;
                    stateNext = MEM_ACC;
                end else if (if_req_i && !ifServed) begin
                    grantIf   = 1'b1;
                    stateNext = IF_ACC;
                end
            end
            MEM_ACC, IF_ACC: begin
                if (memPort.port_ack_i || timedOut) begin
                    accDone   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            memPort.port_req_o   <= 1'b0;
            memPort.port_we_o    <= 1'b0;
            memPort.port_addr_o  <= '0;
            memPort.port_wdata_o <= '0;
            ifServed             <= 1'b0;
            memServed            <= 1'b0;
            if_rdata_o           <= '0;
            mem_rdata_o          <= '0;
        end else begin
            if (grantMem) begin
                memPort.port_req_o   <= 1'b1;
                memPort.port_we_o    <= mem_we_i;
                memPort.port_addr_o  <= mem_addr_i;
                memPort.port_wdata_o <= mem_wdata_i;
            end else if (grantIf) begin
                memPort.port_req_o  <= 1'b1;
                memPort.port_we_o   <= 1'b0;
                memPort.port_addr_o <= if_addr_i;
            end else if (accDone) begin
                memPort.port_req_o <= 1'b0;
            end

            // Stall is high throughout an access, so setting and clearing a flag never collide.
            if (!pipe_stall_o) begin
                ifServed  <= 1'b0;
                memServed <= 1'b0;
            end else if (accDone) begin
                if (state == IF_ACC) ifServed <= 1'b1;
                else                 memServed <= 1'b1;
            end

            if (accDone && state == IF_ACC) begin
                if_rdata_o <= timedOut ? '0 : memPort.port_rdata_i;
            end
            if (accDone && state == MEM_ACC && !memPort.port_we_o) begin
                mem_rdata_o <= timedOut ? '0 : memPort.port_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected port accesses and slot results are queued by the driver
// and compared by independent monitors; a responder process models the memory's ack timing.
module tb_mem_port_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cycles;
    } acc_t;

    typedef struct {
        int          delay;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic [31:0] ifr;
        logic [31:0] memr;
        int          stall;
    } slot_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [31:0] if_rdata_o, mem_rdata_o;
    logic        pipe_stall_o, err_o;

    int nChecks = 0;
    int nErrors = 0;

    acc_t  accQ[$];
    rsp_t  rspQ[$];
    slot_t slotQ[$];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .mem_req_i    (mem_req_i),
        .mem_we_i     (mem_we_i),
        .mem_addr_i   (mem_addr_i),
        .mem_wdata_i  (mem_wdata_i),
        .if_rdata_o   (if_rdata_o),
        .mem_rdata_o  (mem_rdata_o),
        .pipe_stall_o (pipe_stall_o),
        .err_o        (err_o),
        .memPort      (bus.master)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Port monitor: each new request is compared against the next expected access.
    initial begin : portMonitor
        acc_t        cur;
        logic        prevReq = 1'b0;
        int          accCnt = 0;
        logic        lwe;
        logic [31:0] laddr, lwdata;
        cur = '{we: 1'b0, addr: '0, wdata: '0, cycles: 0};
        forever begin
            @(negedge clk_i);
            if (bus.port_req_o) begin
                if (!prevReq) begin
                    if (accQ.size() == 0) begin
                        check("unexpected_port_access", 64'(bus.port_addr_o), 64'hFFFF_FFFF);
                        cur = '{we: 1'b0, addr: '0, wdata: '0, cycles: -1};
                    end else begin
                        cur = accQ.pop_front();
                        check("acc_we", 64'(bus.port_we_o), 64'(cur.we));
                        check("acc_addr", 64'(bus.port_addr_o), 64'(cur.addr));
                        if (cur.we) check("acc_wdata", 64'(bus.port_wdata_o), 64'(cur.wdata));
                    end
                    lwe    = bus.port_we_o;
                    laddr  = bus.port_addr_o;
                    lwdata = bus.port_wdata_o;
                    accCnt = 1;
                end else begin
                    check("acc_stable", {bus.port_we_o, bus.port_addr_o, bus.port_wdata_o},
                          {lwe, laddr, lwdata});
                    accCnt++;
                end
            end else if (prevReq) begin
                check("acc_cycles", 64'(accCnt), 64'(cur.cycles));
            end
            prevReq = bus.port_req_o;
        end
    end

    // Slot monitor: a slot completes at a negedge where requests are present but stall is low.
    initial begin : slotMonitor
        slot_t exp;
        int    stallCnt = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                stallCnt = 0;
            end else if (pipe_stall_o) begin
                stallCnt++;
            end else if (if_req_i || mem_req_i) begin
                if (slotQ.size() == 0) begin
                    check("unexpected_slot_end", 64'(stallCnt), 64'hFFFF_FFFF);
                end else begin
                    exp = slotQ.pop_front();
                    check("slot_if_rdata", 64'(if_rdata_o), 64'(exp.ifr));
                    check("slot_mem_rdata", 64'(mem_rdata_o), 64'(exp.memr));
                    check("slot_stall_cycles", 64'(stallCnt), 64'(exp.stall));
                end
                stallCnt = 0;
            end
        end
    end

    // Memory responder: delay < 0 means never acknowledge.
    initial begin : responder
        rsp_t r;
        bus.port_ack_i   = 1'b0;
        bus.port_rdata_i = 32'hFFFF_FFFF;
        forever begin
            @(negedge clk_i);
            if (bus.port_req_o && rst_i) begin
                if (rspQ.size() == 0) begin
                    check("responder_queue_empty", 64'(bus.port_addr_o), 64'hFFFF_FFFF);
                    for (int i = 0; i < 50 && bus.port_req_o; i++) @(negedge clk_i);
                end else begin
                    r = rspQ.pop_front();
                    if (r.delay < 0) begin
                        for (int i = 0; i < 50 && bus.port_req_o; i++) @(negedge clk_i);
                    end else begin
                        repeat (r.delay) @(negedge clk_i);
                        bus.port_ack_i   = 1'b1;
                        bus.port_rdata_i = r.data;
                        @(posedge clk_i);
                        #1;
                        bus.port_ack_i   = 1'b0;
                        bus.port_rdata_i = 32'hFFFF_FFFF;
                    end
                end
            end
        end
    end

    task automatic startSlot(input logic ifReq, input logic [31:0] ifAddr, input logic memReq,
                             input logic memWe, input logic [31:0] memAddr, input logic [31:0] memWdata);
        if_req_i    = ifReq;
        if_addr_i   = ifAddr;
        mem_req_i   = memReq;
        mem_we_i    = memWe;
        mem_addr_i  = memAddr;
        mem_wdata_i = memWdata;
    endtask

    task automatic finishSlot(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk_i);
            if (!pipe_stall_o) done = 1'b1;
        end
        check(name, 64'(done), 64'd1);
        @(posedge clk_i);
        #1;
        startSlot(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bit seen;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("rst_port_req", 64'(bus.port_req_o), 64'd0);
        check("rst_port_bus", {bus.port_we_o, bus.port_addr_o, bus.port_wdata_o}, 64'd0);
        check("rst_rdata", {if_rdata_o, mem_rdata_o}, 64'd0);
        check("rst_err_stall", {err_o, pipe_stall_o}, 64'd0);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset in the middle of an IF access.
        accQ.push_back('{we: 1'b0, addr: 32'h40, wdata: '0, cycles: 2});
        rspQ.push_back('{delay: 6, data: 32'h1111_1111});
        startSlot(1'b1, 32'h40, 1'b0, 1'b0, '0, '0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk_i);
            #1;
            if (bus.port_req_o) seen = 1'b1;
        end
        check("mid_rst_req_seen", 64'(seen), 64'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        if_req_i = 1'b0;
        #1;
        check("mid_rst_req_drop", 64'(bus.port_req_o), 64'd0);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        repeat (8) @(posedge clk_i);
        #1;
        check("post_rst_idle", 64'(bus.port_req_o), 64'd0);
        check("post_rst_ack_ignored", 64'(if_rdata_o), 64'd0);

        // IF-only fetch; stall rising at once also shows the served flag was cleared.
        accQ.push_back('{we: 1'b0, addr: 32'h10, wdata: '0, cycles: 1});
        rspQ.push_back('{delay: 0, data: 32'h00A0_0093});
        slotQ.push_back('{ifr: 32'h00A0_0093, memr: 32'h0, stall: 2});
        startSlot(1'b1, 32'h10, 1'b0, 1'b0, '0, '0);
        #1;
        check("post_rst_if_unserved", 64'(pipe_stall_o), 64'd1);
        finishSlot("if_only_done");

        // Simultaneous load + fetch: MEM first.
        accQ.push_back('{we: 1'b0, addr: 32'h100, wdata: '0, cycles: 1});
        accQ.push_back('{we: 1'b0, addr: 32'h14, wdata: '0, cycles: 1});
        rspQ.push_back('{delay: 0, data: 32'h1234_5678});
        rspQ.push_back('{delay: 0, data: 32'h0000_006F});
        slotQ.push_back('{ifr: 32'h0000_006F, memr: 32'h1234_5678, stall: 4});
        startSlot(1'b1, 32'h14, 1'b1, 1'b0, 32'h100, '0);
        finishSlot("both_done");

        // Store must be issued once while IF waits 4 extra cycles.
        accQ.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'hDEAD_BEEF, cycles: 1});
        accQ.push_back('{we: 1'b0, addr: 32'h18, wdata: '0, cycles: 5});
        rspQ.push_back('{delay: 0, data: 32'h0});
        rspQ.push_back('{delay: 4, data: 32'h0000_0013});
        slotQ.push_back('{ifr: 32'h0000_0013, memr: 32'h1234_5678, stall: 8});
        startSlot(1'b1, 32'h18, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF);
        finishSlot("store_once_done");

        // Wait states on a store, then on a load.
        accQ.push_back('{we: 1'b1, addr: 32'h300, wdata: 32'hCAFE_F00D, cycles: 4});
        rspQ.push_back('{delay: 3, data: 32'h0});
        slotQ.push_back('{ifr: 32'h0000_0013, memr: 32'h1234_5678, stall: 5});
        startSlot(1'b0, '0, 1'b1, 1'b1, 32'h300, 32'hCAFE_F00D);
        finishSlot("wait_store_done");

        accQ.push_back('{we: 1'b0, addr: 32'h104, wdata: '0, cycles: 3});
        rspQ.push_back('{delay: 2, data: 32'hA5A5_5A5A});
        slotQ.push_back('{ifr: 32'h0000_0013, memr: 32'hA5A5_5A5A, stall: 4});
        startSlot(1'b0, '0, 1'b1, 1'b0, 32'h104, '0);
        finishSlot("wait_load_done");

        // Empty slot: no stall, no port activity.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("empty_slot", {bus.port_req_o, pipe_stall_o}, 64'd0);
        end
        @(posedge clk_i);
        #1;

`ifdef MEM_ARB_TIMEOUT_EN
        accQ.push_back('{we: 1'b0, addr: 32'h20, wdata: '0, cycles: 4});
        rspQ.push_back('{delay: -1, data: 32'h0});
        slotQ.push_back('{ifr: 32'h0, memr: 32'hA5A5_5A5A, stall: 5});
        startSlot(1'b1, 32'h20, 1'b0, 1'b0, '0, '0);
        finishSlot("timeout_done");
        check("timeout_err_set", 64'(err_o), 64'd1);

        accQ.push_back('{we: 1'b0, addr: 32'h24, wdata: '0, cycles: 1});
        rspQ.push_back('{delay: 0, data: 32'h0000_0033});
        slotQ.push_back('{ifr: 32'h0000_0033, memr: 32'hA5A5_5A5A, stall: 2});
        startSlot(1'b1, 32'h24, 1'b0, 1'b0, '0, '0);
        finishSlot("after_timeout_done");
        check("timeout_err_sticky", 64'(err_o), 64'd1);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        check("timeout_err_reset", 64'(err_o), 64'd0);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
`else
        check("err_tied_low", 64'(err_o), 64'd0);
`endif

        repeat (5) @(posedge clk_i);
        #1;
        check("acc_queue_drained", 64'(accQ.size()), 64'd0);
        check("rsp_queue_drained", 64'(rspQ.size()), 64'd0);
        check("slot_queue_drained", 64'(slotQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
